// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared defaults and scheduler state encoding for the JPEG RLE path
package jpeg_pkg;
  localparam int DEFAULT_NUM_ELEMS = 64;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ENC_TIMEOUT = 128;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ENCODE,
    ST_DRAIN,
    ST_EOB
  } state_e;
endpackage

// File: rtl/rle_block_scheduler.sv
// rle_block_scheduler: sequences one zigzag block through the RLE encoder and streams its run pairs plus an EOB word
module rle_block_scheduler
  import jpeg_pkg::*;
#(
  parameter int NUM_ELEMS = DEFAULT_NUM_ELEMS,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ENC_TIMEOUT = DEFAULT_ENC_TIMEOUT
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        block_valid_in,
  output logic                        block_ready_out,
  output logic                        enc_rst_out,
  output logic                        enc_valid_out,
  input  logic                        enc_done_in,
  input  logic [6:0]                  enc_runs_in,
  input  logic [NUM_ELEMS*DATA_W-1:0] enc_value_in,
  input  logic [NUM_ELEMS*DATA_W-1:0] enc_count_in,
  output logic                        pair_valid_out,
  input  logic                        pair_ready_in,
  output logic [DATA_W-1:0]           pair_value_out,
  output logic [DATA_W-1:0]           pair_count_out,
  output logic                        pair_last_out,
  output logic                        busy_out,
  output logic                        timeout_err_out,
  output logic [15:0]                 blocks_done_out
);
  localparam int IW = $clog2(NUM_ELEMS + 1);
  localparam int TW = $clog2(ENC_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, runs_q, runs_d, runs_clip;
  logic [TW-1:0] timer_q, timer_d;
  logic abort_q, abort_d, timeout_q, timeout_d;
  logic [15:0] blocks_done_q, blocks_done_d;
  logic enc_expired;
  assign runs_clip = (32'(enc_runs_in) > NUM_ELEMS) ? IW'(NUM_ELEMS) : IW'(enc_runs_in);
  assign enc_expired = timer_q == TW'(ENC_TIMEOUT - 1);
  assign block_ready_out = state_q == ST_IDLE;
  assign busy_out = state_q != ST_IDLE;
  // encoder is held in reset during our own reset, for the CLEAR cycle and for one cycle after an abort
  assign enc_rst_out = !rst_n_in || state_q == ST_CLEAR || abort_q;
  assign enc_valid_out = state_q == ST_ENCODE;
  assign pair_valid_out = state_q == ST_DRAIN || state_q == ST_EOB;
  assign pair_last_out = state_q == ST_EOB;
  assign pair_value_out = state_q == ST_DRAIN ? enc_value_in[idx_q*DATA_W +: DATA_W] : '0;
  assign pair_count_out = state_q == ST_DRAIN ? enc_count_in[idx_q*DATA_W +: DATA_W] : '0;
  assign timeout_err_out = timeout_q;
  assign blocks_done_out = blocks_done_q;
  // next-state logic; an empty run list skips DRAIN so no pair is emitted before EOB
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    runs_d = runs_q;
    timer_d = timer_q;
    abort_d = 1'b0;
    timeout_d = timeout_q;
    blocks_done_d = blocks_done_q;
    case (state_q)
      ST_IDLE: state_d = block_valid_in ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: begin
        state_d = ST_ENCODE;
        timer_d = '0;
      end
      ST_ENCODE: begin
        if (enc_done_in) begin
          runs_d = runs_clip;
          idx_d = '0;
          state_d = runs_clip == '0 ? ST_EOB : ST_DRAIN;
        end else if (enc_expired) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (pair_ready_in) begin
          idx_d = idx_q + IW'(1);
          state_d = (idx_q + IW'(1) == runs_q) ? ST_EOB : ST_DRAIN;
        end
      end
      ST_EOB: begin
        if (pair_ready_in) begin
          blocks_done_d = blocks_done_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state registers, cleared asynchronously so a block in flight is abandoned at once
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      runs_q <= '0;
      timer_q <= '0;
      abort_q <= 1'b0;
      timeout_q <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      runs_q <= runs_d;
      timer_q <= timer_d;
      abort_q <= abort_d;
      timeout_q <= timeout_d;
      blocks_done_q <= blocks_done_d;
    end
  end
endmodule

// File: doc/rle_block_scheduler.md
RLE_BLOCK_SCHEDULER -- requirements
Module: rle_block_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_ELEMS, 64, coefficients per block; DATA_W, 8, value/count width; ENC_TIMEOUT, 128, max cycles in ENCODE before abort.
REQ-002 Ports SHALL be, in order:
- clk_in  input  1  single clock, all logic on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- block_valid_in  input  1  upstream zigzag block available
- block_ready_out  output  1  scheduler can accept a block
- enc_rst_out  output  1  active-high reset to the RLE encoder
- enc_valid_out  output  1  encoder enable
- enc_done_in  input  1  encoder finished
- enc_runs_in  input  7  number of runs reported by encoder
- enc_value_in  input  NUM_ELEMS x DATA_W  encoder run values
- enc_count_in  input  NUM_ELEMS x DATA_W  encoder run lengths
- pair_valid_out  output  1  output pair valid
- pair_ready_in  input  1  downstream accepts pair
- pair_value_out  output  DATA_W  run value
- pair_count_out  output  DATA_W  run length
- pair_last_out  output  1  end-of-block word
- busy_out  output  1  high in any state but IDLE
- timeout_err_out  output  1  sticky encoder-timeout flag
- blocks_done_out  output  16  completed-block counter

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, ENCODE, DRAIN, EOB.
REQ-004 block_ready_out SHALL equal (state==IDLE); a block is accepted on a cycle with block_valid_in && block_ready_out.
REQ-005 On acceptance, next state SHALL be CLEAR; enc_rst_out SHALL be high for exactly that one CLEAR cycle.
REQ-006 CLEAR SHALL always go to ENCODE; enc_valid_out SHALL be high in every ENCODE cycle and low otherwise.
REQ-007 In ENCODE, enc_done_in high SHALL move to DRAIN, latch runs = min(enc_runs_in, NUM_ELEMS), and zero the read index.
REQ-008 A cycle counter SHALL clear on entering ENCODE; reaching ENC_TIMEOUT without enc_done_in SHALL set timeout_err_out, pulse enc_rst_out one cycle, and return to IDLE without emitting pairs or incrementing blocks_done_out.
REQ-009 In DRAIN, pair_valid_out SHALL be high with pair_value_out/pair_count_out = enc_value_in[idx]/enc_count_in[idx], pair_last_out low; idx SHALL advance only on pair_valid_out && pair_ready_in.
REQ-010 When idx reaches latched runs after a handshake, next state SHALL be EOB; latched runs == 0 SHALL go directly from DRAIN entry to EOB with no pair emitted.
REQ-011 In EOB, output SHALL be value 0, count 0, pair_last_out 1, pair_valid_out 1; on handshake blocks_done_out SHALL increment (wrapping 0xFFFF -> 0) and state SHALL go to IDLE.
REQ-012 Output data SHALL be held stable while pair_valid_out && !pair_ready_in.
REQ-013 Minimum latency, accept to first pair valid, SHALL be 3 cycles + encoder time; back-to-back blocks SHALL be separated by at least one IDLE cycle.
REQ-014 block_valid_in during non-IDLE states SHALL be ignored; upstream SHALL hold block data stable until busy_out falls.
REQ-015 timeout_err_out SHALL clear only by reset.

Reset
REQ-016 While rst_n_in low: state IDLE, enc_rst_out 1, enc_valid_out 0, pair_valid_out 0, pair_value_out 0, pair_count_out 0, pair_last_out 0, busy_out 0, timeout_err_out 0, blocks_done_out 0, idx/runs/timer 0.
REQ-017 Reset assertion mid-block SHALL abandon the block immediately; first cycle after deassertion SHALL be IDLE with block_ready_out 1.

Structure
REQ-018 State enum, NUM_ELEMS, DATA_W and ENC_TIMEOUT defaults SHALL live in shared package jpeg_pkg.
REQ-019 The design SHALL be one module with no sub-modules; the encoder is instantiated by the parent beside it.

Verification
REQ-020 Bench SHALL cover:
- Single block, encoder model reports runs=3 (5/1,0/3,4/60), ready tied 1 -> pairs (5,1),(0,3),(4,60),(0,0,last), blocks_done_out=1.
- Same block, pair_ready_in toggled 1-0-0-1 -> no duplicate or dropped pair, outputs stable during stalls.
- Encoder never asserts done -> after 128 ENCODE cycles timeout_err_out=1, IDLE, no pairs, blocks_done_out unchanged.
- enc_runs_in=0 -> only EOB word emitted; enc_runs_in=100 -> exactly 64 pairs then EOB.
- rst_n_in pulsed low during DRAIN idx=2 -> all outputs at reset values, next block processed normally.
- blocks_done_out preloaded via 65536 blocks (or forced) -> wraps to 0.
